// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small transmit FIFO in front of the serializer.
// Handshake: a word is taken on a rising edge where i_valid && o_ready; i_valid while o_ready is low is ignored and i_data may change.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_signal,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic [2:0]                    o_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q;
  logic                 push, pop, fifo_empty;
  logic [DATA_BITS-1:0] head;

  state_t               state_q, state_d;
  logic [15:0]          baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 stop_q, stop_d;
  logic                 sig_q, sig_d;
  logic                 load, baud_done, stop_last;

  assign o_ready    = (count_q != FULL);
  assign push       = i_valid && o_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge i_clock) begin
    if (!i_reset && push) mem_q[wr_ptr_q] <= i_data;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      sig_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      sig_q   <= sig_d;
    end
  end

  assign baud_done = (baud_q == '0);
  assign stop_last = (STOP_BITS == 1) || stop_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_d  = stop_q;
    sig_d   = sig_q;
    load    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        sig_d = 1'b1;
        if (!fifo_empty) load = 1'b1;
      end
      S_START: begin
        if (baud_done) begin
          sig_d   = shift_q[0];
          baud_d  = BAUD_LAST;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = BAUD_LAST;
          if (bit_q == LAST_BIT) begin
            if (PARITY != 0) begin
              sig_d   = par_q;
              state_d = S_PARITY;
            end else begin
              sig_d   = 1'b1;
              stop_d  = 1'b0;
              state_d = S_STOP;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            sig_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_PARITY: begin
        if (baud_done) begin
          sig_d   = 1'b1;
          stop_d  = 1'b0;
          baud_d  = BAUD_LAST;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          if (!stop_last) begin
            stop_d = 1'b1;
            baud_d = BAUD_LAST;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            sig_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame launch shared by IDLE and the back-to-back path out of STOP.
    if (load) begin
      pop     = 1'b1;
      shift_d = head;
      par_d   = (PARITY == 1) ? ~(^head) : (^head);
      sig_d   = 1'b0;
      baud_d  = BAUD_LAST;
      state_d = S_START;
    end
  end

  assign o_signal     = sig_q;
  assign o_busy       = (state_q != S_IDLE) || !fifo_empty;
  assign o_fifo_count = count_q;
  assign o_state      = state_q;

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104: clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4: transmit FIFO entries; power of two, 2..64.
REQ-006 i_clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-007 i_reset  input  1  synchronous, active-high reset.
REQ-008 i_data  input  DATA_BITS  word to transmit; sampled only on handshake.
REQ-009 i_valid  input  1  producer offers i_data this cycle.
REQ-010 o_ready  output  1  FIFO can accept a word; equals not-full.
REQ-011 o_signal  output  1  registered serial line; idle high.
REQ-012 o_busy  output  1  high while a frame is in progress or FIFO is non-empty.
REQ-013 o_fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 Handshake: the word SHALL be written into the FIFO on an edge where i_valid && o_ready; i_valid with o_ready low SHALL be ignored, with no drop and no overwrite.
REQ-015 FIFO: first in, first out; read/write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-016 Simultaneous push and pop in one cycle SHALL leave the count unchanged and preserve order.
REQ-017 States: IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: o_signal=1; if FIFO non-empty, pop the head into the shift register, drive o_signal=0 on the same edge, load the baud counter, and go to START.
REQ-019 Each state SHALL hold its line value for exactly CLKS_PER_BIT cycles, counted by a baud counter reloaded with CLKS_PER_BIT-1 and decremented to 0.
REQ-020 START to DATA: drive bit 0; DATA SHALL send DATA_BITS bits LSB first, using a bit index counter of width clog2(DATA_BITS).
REQ-021 After the last data bit, go to PARITY if PARITY!=0, else STOP.
REQ-022 Parity bit: XOR of the data bits for even; its inverse for odd; computed from the popped word, not from live i_data.
REQ-023 STOP: o_signal=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-024 At the end of STOP: if FIFO non-empty, pop and enter START on the same edge (back-to-back frames, zero idle cycles); else go to IDLE.
REQ-025 Frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles exactly.
REQ-026 Latency: word accepted at edge N with FIFO empty and state IDLE; o_signal SHALL fall after edge N+1.
REQ-027 o_busy SHALL fall on the edge that returns to IDLE with FIFO empty; it SHALL stay high across back-to-back frames.
REQ-028 A push while the FIFO is full and a pop occurs in the same cycle SHALL NOT happen (o_ready low); no bypass path exists.

Reset
REQ-029 With i_reset high at an edge: state=IDLE, o_signal=1, o_busy=0, FIFO flushed (count 0, pointers 0), baud and bit counters 0; o_ready=1 after that edge.
REQ-030 Reset mid-frame SHALL abort the frame: the line returns high on the next edge and queued words are discarded.
REQ-031 i_reset SHALL take priority over a simultaneous handshake; that word is dropped.
REQ-032 With i_reset held, o_signal SHALL stay 1 and no handshake SHALL be accepted.

Verification
REQ-033 CLKS_PER_BIT=4, 8N1; send 0xA5 -> o_signal = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, 40 cycles total; o_busy then falls.
REQ-034 8E1; send 0x07 -> parity bit 1; 8O1 with 0x07 -> parity bit 0; frame 44 cycles at CLKS_PER_BIT=4.
REQ-035 FIFO_DEPTH=4, tx busy: offer 5 words back-to-back -> 4 accepted, o_ready low, 5th held until the first pop; all 5 transmitted in order.
REQ-036 Two queued words 0x55, 0xAA, 8N2 -> second start bit begins the cycle after the 2nd stop bit ends; no idle gap; o_busy continuously high.
REQ-037 Assert i_reset during data bit 3 of a frame with 2 words queued -> o_signal=1, o_busy=0, o_fifo_count=0 after the edge; a fresh word afterwards transmits correctly.
REQ-038 DATA_BITS=5, CLKS_PER_BIT=2; send 0x1F -> exactly 5 data bits of 1 between start and stop; frame length 14 cycles.
